sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares the single 16-bit off-chip SRAM between the data port (MEM stage) and an
//  instruction-fetch port. Splits each 32-bit access into two 16-bit SRAM phases:
//  low half first, then high half. Tie-breaks with round-robin and returns a
//  one-cycle ack per transaction. Sits between MEM/IF and the SRAM pins;
//  d_ready drives the pipeline freeze.
// PARAMETERS
//  WAIT_CYCLES  1  cycles each 16-bit phase is held on the SRAM pins (legal >= 1)
// PORTS
//  clk        in    1   system clock; all state changes on rising edge
//  rst        in    1   asynchronous, active-low reset
//  d_req      in    1   data request; held with d_we/d_addr/d_wdata stable until d_ack
//  d_we       in    1   1 = write, 0 = read
//  d_addr     in    32  byte address; bits [18:2] used, others ignored
//  d_wdata    in    32  write data
//  d_rdata    out   32  read data, registered; valid in the d_ack cycle, held until next data read completes
//  d_ack      out   1   one-cycle pulse: data transaction complete
//  d_ready    out   1   combinational: ~d_req | d_ack (0 = freeze pipeline)
//  i_req      in    1   fetch request (read-only); held with i_addr stable until i_ack
//  i_addr     in    32  byte address; bits [18:2] used
//  i_rdata    out   32  fetch data, registered; valid in the i_ack cycle, held until next fetch completes
//  i_ack      out   1   one-cycle pulse: fetch complete
//  SRAM_ADDR  out   18  SRAM half-word address
//  SRAM_DQ    inout 16  SRAM data; driven only in write phases, else 'z
//  SRAM_WE_N  out   1   SRAM write enable, active low
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ='z,
//    d_ack=i_ack=0, d_rdata=i_rdata=0, last_grant=INSTR (first tie goes to data).
//  - FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
//  - IDLE: if any req is sampled, latch owner, we, word address addr[18:2] and wdata;
//    then go to LO.
//    - Only one req: grant it.
//    - Both reqs: grant the port != last_grant, then set last_grant to the granted port.
//  - LO: SRAM_ADDR={wa,1'b0}. For a write, DQ=wdata[15:0] and WE_N=0 for all
//    WAIT_CYCLES cycles. A wait counter counts 0..WAIT_CYCLES-1. On the final
//    cycle, a read captures DQ into data[15:0]; then go to HI.
//  - HI: same as LO with SRAM_ADDR={wa,1'b1}, data[31:16] / wdata[31:16].
//  - DONE: WE_N=1, DQ='z. Pulse ack of owner for exactly one cycle.
//    - Owner read: rdata<=assembled word, visible in the ack cycle.
//    - Owner write: rdata unchanged.
//    Then go to IDLE. No back-to-back: the next grant is sampled in IDLE, the cycle after DONE.
//  - Latency: req sampled at IDLE edge N -> ack high in cycle N+2*WAIT_CYCLES+1
//    (WAIT_CYCLES=1: 3 cycles).
//  - Requests arriving while busy wait in IDLE arbitration; no queueing beyond the held req.
//  - Req deasserted mid-transaction: the transaction completes and the ack still pulses.
//    Inputs are not resampled after the latch.
//  - Ports are not mutually exclusive in time; at most one ack is high per cycle.
//  - Between phases WE_N is driven 1 for zero cycles. The LO->HI address change
//    with WE_N low is allowed (SRAM latches on address).
//  - Reset mid-transaction: abort immediately to reset values; no ack is issued.
// TESTING
//  1. Data write d_addr=0x10, wdata=0xDEADBEEF -> SRAM_ADDR 0x8 then 0x9 with DQ 0xBEEF, 0xDEAD;
//     WE_N=0 two cycles; d_ack at cycle 3.
//  2. Data read of 0x10 after test 1 -> d_rdata=0xDEADBEEF in the d_ack cycle.
//     d_ready=0 from req until ack, then 1.
//  3. d_req and i_req together from reset -> data served first, then fetch.
//     Holding both -> grants alternate D,I,D,I; no starvation.
//  4. WAIT_CYCLES=3 -> each phase 3 cycles, ack 7 cycles after sampling.
//     Read data captured on the 3rd cycle of each phase.
//  5. Drop d_req one cycle after grant -> phases complete, d_ack still pulses once, FSM back to IDLE.
//  6. Assert rst low during HI of a write -> WE_N=1, DQ='z asynchronously; no ack; IDLE after release.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// CPU-side bundle of the SRAM arbiter: data (MEM) port and fetch (IF) port.
// The pipeline side is the master, the arbiter the slave.
interface sram_arbiter_if;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_ready;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;

    modport master (
        output d_req, d_we, d_addr, d_wdata, i_req, i_addr,
        input  d_rdata, d_ack, d_ready, i_rdata, i_ack
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, i_req, i_addr,
        output d_rdata, d_ack, d_ready, i_rdata, i_ack
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one 16-bit SRAM between data and fetch ports;
// each 32-bit access runs as a low phase then a high phase.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus,
    output logic [17:0]   SRAM_ADDR,
    inout  wire  [15:0]   SRAM_DQ,
    output logic          SRAM_WE_N
);
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          own_q, own_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [16:0]   wa_q, wa_d;
    logic [31:0]   wd_q, wd_d;
    logic [15:0]   lo_q, lo_d;
    logic [31:0]   drd_q, drd_d;
    logic [31:0]   ird_q, ird_d;

    logic          phase_end;
    logic          gnt_i;
    logic          wr_phase;
    logic [15:0]   wr_half;
    logic          unused;

    assign phase_end = (cnt_q == CNT_LAST);
    // Fetch wins when alone, or on a tie when data went last.
    assign gnt_i     = bus.i_req && (!bus.d_req || last_q == OWN_D);
    assign wr_phase  = we_q && (state_q == S_LO || state_q == S_HI);
    assign wr_half   = (state_q == S_HI) ? wd_q[31:16] : wd_q[15:0];

    assign SRAM_ADDR = {wa_q, state_q == S_HI};
    assign SRAM_WE_N = !wr_phase;
    assign SRAM_DQ   = wr_phase ? wr_half : 16'bz;

    assign bus.d_ack   = (state_q == S_DONE) && (own_q == OWN_D);
    assign bus.i_ack   = (state_q == S_DONE) && (own_q == OWN_I);
    assign bus.d_ready = !bus.d_req || bus.d_ack;
    assign bus.d_rdata = drd_q;
    assign bus.i_rdata = ird_q;

    assign unused = ^{bus.d_addr[31:19], bus.d_addr[1:0],
                      bus.i_addr[31:19], bus.i_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        last_d  = last_q;
        we_d    = we_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        lo_d    = lo_q;
        drd_d   = drd_q;
        ird_d   = ird_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.d_req || bus.i_req) begin
                    own_d   = gnt_i;
                    we_d    = !gnt_i && bus.d_we;
                    wa_d    = gnt_i ? bus.i_addr[18:2] : bus.d_addr[18:2];
                    wd_d    = bus.d_wdata;
                    cnt_d   = '0;
                    state_d = S_LO;
                    if (bus.d_req && bus.i_req) last_d = gnt_i;
                end
            end
            S_LO: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = S_HI;
                    if (!we_q) lo_d = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HI: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (own_q == OWN_I) ird_d = {SRAM_DQ, lo_q};
                        else                drd_d = {SRAM_DQ, lo_q};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            own_q   <= OWN_D;
            last_q  <= OWN_I;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            lo_q    <= '0;
            drd_q   <= '0;
            ird_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
            last_q  <= last_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            lo_q    <= lo_d;
            drd_q   <= drd_d;
            ird_q   <= ird_d;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table, corner sequences, and a
// transaction-level random model against an SRAM array.
module tb_sram_arbiter;
    logic clk;
    logic rst;

    sram_arbiter_if bus1 ();
    sram_arbiter_if bus3 ();

    logic [17:0] sa1;
    wire  [15:0] dq1;
    logic        wen1;
    logic [17:0] sa3;
    wire  [15:0] dq3;
    logic        wen3;
    logic [15:0] dq3_val;

    logic [15:0] mem [0:262143];

    sram_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .SRAM_ADDR(sa1), .SRAM_DQ(dq1), .SRAM_WE_N(wen1)
    );

    sram_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .SRAM_ADDR(sa3), .SRAM_DQ(dq3), .SRAM_WE_N(wen3)
    );

    assign dq1 = wen1 ? mem[sa1] : 16'bz;
    assign dq3 = wen3 ? dq3_val : 16'bz;

    always @(posedge clk) if (!wen1) mem[sa1] = dq1;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] pat(input logic [17:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0;  bus1.d_wdata = '0;
        bus1.i_req = 1'b0; bus1.i_addr = '0;
        bus3.d_req = 1'b0; bus3.d_we = 1'b0;
        bus3.d_addr = '0;  bus3.d_wdata = '0;
        bus3.i_req = 1'b0; bus3.i_addr = '0;
    endtask

    typedef struct {
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        dack;
        logic        ready;
        logic        wen;
        logic [17:0] sa;
        logic        chk_sa;
        logic        chk_dq;
        logic [15:0] dq;
        logic [31:0] rd;
    } vec_t;

    vec_t tv [10];

    // Transaction-level reference model state
    logic [31:0] wmem [int];
    int          free_c;
    int          ack_c;
    logic        m_own_i;
    logic        m_last_i;
    logic        m_wr;
    logic [31:0] m_pend;
    logic [31:0] m_drd;
    logic [31:0] m_ird;
    logic [31:0] a;
    logic        gi;
    logic        e_d;
    logic        e_i;
    int          wa;

    function automatic logic [31:0] model_rd(input int w);
        logic [17:0] b;
        if (wmem.exists(w)) return wmem[w];
        b = 18'(w) << 1;
        return {pat(b | 18'd1), pat(b)};
    endfunction

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = pat(18'(i));
        clk = 1'b0;
        dq3_val = '0;
        idle_inputs();

        tv[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1,
                  18'h0, 1'b1, 1'b0, 16'h0, 32'h0};
        tv[1] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0,
                  18'h8, 1'b1, 1'b1, 16'hBEEF, 32'h0};
        tv[2] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0,
                  18'h9, 1'b1, 1'b1, 16'hDEAD, 32'h0};
        tv[3] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1,
                  18'h0, 1'b0, 1'b0, 16'h0, 32'h0};
        tv[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1,
                  18'h0, 1'b0, 1'b0, 16'h0, 32'h0};
        tv[5] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1,
                  18'h0, 1'b0, 1'b0, 16'h0, 32'h0};
        tv[6] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1,
                  18'h8, 1'b1, 1'b0, 16'h0, 32'h0};
        tv[7] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1,
                  18'h9, 1'b1, 1'b0, 16'h0, 32'h0};
        tv[8] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1,
                  18'h0, 1'b0, 1'b0, 16'h0, 32'hDEADBEEF};
        tv[9] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1,
                  18'h0, 1'b0, 1'b0, 16'h0, 32'hDEADBEEF};

        // Reset state, sampled while reset is held
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst.wen", wen1, 1'b1);
        chk("rst.addr", 32'(sa1), 32'h0);
        chk1("rst.dack", bus1.d_ack, 1'b0);
        chk1("rst.iack", bus1.i_ack, 1'b0);
        chk("rst.drd", bus1.d_rdata, 32'h0);
        chk("rst.ird", bus1.i_rdata, 32'h0);
        chk1("rst.wen3", wen3, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        // Write then read of 0x10 from the vector table
        for (int k = 0; k < 10; k++) begin
            bus1.d_req   = tv[k].dreq;
            bus1.d_we    = tv[k].dwe;
            bus1.d_addr  = tv[k].daddr;
            bus1.d_wdata = tv[k].dwd;
            #1;
            chk1($sformatf("v%0d.dack", k), bus1.d_ack, tv[k].dack);
            chk1($sformatf("v%0d.iack", k), bus1.i_ack, 1'b0);
            chk1($sformatf("v%0d.ready", k), bus1.d_ready, tv[k].ready);
            chk1($sformatf("v%0d.wen", k), wen1, tv[k].wen);
            chk($sformatf("v%0d.drd", k), bus1.d_rdata, tv[k].rd);
            if (tv[k].chk_sa)
                chk($sformatf("v%0d.addr", k), 32'(sa1), 32'(tv[k].sa));
            if (tv[k].chk_dq)
                chk($sformatf("v%0d.dq", k), 32'(dq1), 32'(tv[k].dq));
            @(negedge clk);
        end

        // Simultaneous requests from reset: D, I, D, I
        idle_inputs();
        do_reset();
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h10;
        bus1.i_req = 1'b1; bus1.i_addr = 32'h20;
        for (int c = 0; c < 16; c++) begin
            #1;
            chk1($sformatf("rr%0d.dack", c), bus1.d_ack, c == 3 || c == 11);
            chk1($sformatf("rr%0d.iack", c), bus1.i_ack, c == 7 || c == 15);
            if (c == 3) chk("rr.drd", bus1.d_rdata, 32'hDEADBEEF);
            if (c == 7) chk("rr.ird", bus1.i_rdata, {pat(18'd17), pat(18'd16)});
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);

        // Request dropped one cycle after grant
        for (int c = 0; c < 7; c++) begin
            if (c == 0) begin
                bus1.d_req = 1'b1; bus1.d_we = 1'b1;
                bus1.d_addr = 32'h404; bus1.d_wdata = 32'h12345678;
            end else begin
                bus1.d_req = 1'b0;
            end
            #1;
            chk1($sformatf("drop%0d.dack", c), bus1.d_ack, c == 3);
            chk1($sformatf("drop%0d.wen", c), wen1, !(c == 1 || c == 2));
            if (c == 1) chk1("drop.ready", bus1.d_ready, 1'b1);
            @(negedge clk);
        end
        chk("drop.memlo", 32'(mem[18'd514]), 32'h5678);
        chk("drop.memhi", 32'(mem[18'd515]), 32'h1234);
        idle_inputs();

        // WAIT_CYCLES=3 read with data valid only on each phase's last cycle
        for (int c = 0; c < 10; c++) begin
            if (c == 0) begin
                bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h40;
            end
            dq3_val = (c == 3) ? 16'h3344 : (c == 6) ? 16'h1122 : 16'hFFF0 ^ 16'(c);
            #1;
            chk1($sformatf("w3_%0d.dack", c), bus3.d_ack, c == 7);
            if (c >= 1 && c <= 3) chk($sformatf("w3_%0d.addr", c), 32'(sa3), 32'd32);
            if (c >= 4 && c <= 6) chk($sformatf("w3_%0d.addr", c), 32'(sa3), 32'd33);
            if (c == 7) begin
                chk("w3.drd", bus3.d_rdata, 32'h11223344);
                bus3.d_req = 1'b0;
            end
            @(negedge clk);
        end
        idle_inputs();

        // Reset during the high phase of a write
        bus1.d_req = 1'b1; bus1.d_we = 1'b1;
        bus1.d_addr = 32'h400; bus1.d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk1("rsthi.wen_pre", wen1, 1'b0);
        rst = 1'b0;
        #1;
        chk1("rsthi.wen", wen1, 1'b1);
        chk("rsthi.addr", 32'(sa1), 32'h0);
        chk1("rsthi.dack", bus1.d_ack, 1'b0);
        bus1.d_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1($sformatf("rsthi%0d.dack", c), bus1.d_ack, 1'b0);
            chk1($sformatf("rsthi%0d.wen", c), wen1, 1'b1);
        end
        bus1.d_we = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus1.d_req = (c < 4);
            #1;
            chk1($sformatf("rb%0d.dack", c), bus1.d_ack, c == 3);
            if (c == 3) chk("rb.drd", bus1.d_rdata, {pat(18'd513), 16'hF00D});
            @(negedge clk);
        end
        idle_inputs();

        // Randomized traffic against the transaction-level model
        do_reset();
        wmem[4] = 32'hDEADBEEF;
        free_c = 0; ack_c = -1;
        m_own_i = 1'b0; m_last_i = 1'b1; m_wr = 1'b0;
        m_pend = '0; m_drd = '0; m_ird = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            #1;
            e_d = (cyc == ack_c) && !m_own_i;
            e_i = (cyc == ack_c) && m_own_i;
            if (cyc == ack_c && !m_wr) begin
                if (m_own_i) m_ird = m_pend;
                else         m_drd = m_pend;
            end
            chk1("rnd.dack", bus1.d_ack, e_d);
            chk1("rnd.iack", bus1.i_ack, e_i);
            chk1("rnd.ready", bus1.d_ready, !bus1.d_req || e_d);
            chk("rnd.drd", bus1.d_rdata, m_drd);
            chk("rnd.ird", bus1.i_rdata, m_ird);
            if (e_d) bus1.d_req = 1'b0;
            if (e_i) bus1.i_req = 1'b0;
            if (!bus1.d_req && $urandom_range(0, 2) == 0) begin
                a = $urandom;
                a[18:2] = 17'($urandom_range(0, 15));
                bus1.d_addr  = a;
                bus1.d_we    = 1'($urandom_range(0, 1));
                bus1.d_wdata = $urandom;
                bus1.d_req   = 1'b1;
            end
            if (!bus1.i_req && $urandom_range(0, 2) == 0) begin
                a = $urandom;
                a[18:2] = 17'($urandom_range(0, 15));
                bus1.i_addr = a;
                bus1.i_req  = 1'b1;
            end
            if (cyc >= free_c && (bus1.d_req || bus1.i_req)) begin
                if (bus1.d_req && bus1.i_req) begin
                    gi = !m_last_i;
                    m_last_i = gi;
                end else begin
                    gi = bus1.i_req;
                end
                m_own_i = gi;
                wa = gi ? int'(bus1.i_addr[18:2]) : int'(bus1.d_addr[18:2]);
                m_wr = !gi && bus1.d_we;
                if (m_wr) wmem[wa] = bus1.d_wdata;
                else      m_pend = model_rd(wa);
                ack_c  = cyc + 3;
                free_c = cyc + 4;
            end
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
